ysyx_22050019_ifid_buf: RTL and testbench
=========================================

// Module: ysyx_22050019_ifid_buf
// PURPOSE
//  IF->ID decoupling buffer. Sits directly downstream of the fetch stage and upstream of decode.
//  Captures each committed fetch (pc, inst, AXI rresp) into a small FIFO and presents the head entry to the IDU.
//  Back-pressures fetch through pc_stall, and flushes wrong-path entries on a redirect (jump/branch).
// PARAMETERS
//  DEPTH     2             entries; power of 2, >=2
//  PC_W      64            pc width
//  NOP_INST  32'h00000013  instruction driven on id_inst_o when id_valid_o=0 (addi x0,x0,0)
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst_n          in   1     async reset, active-low
//  ifu_valid_i    in   1     fetch committed this cycle (IFU inst_commite)
//  ifu_pc_i       in   PC_W  pc of the committed instruction
//  ifu_inst_i     in   32    committed instruction word (already half-selected)
//  ifu_rresp_i    in   2     AXI rresp of the fetch beat
//  pc_stall_o     out  1     to IFU pc_stall_i; 1 = buffer full, do not commit
//  flush_i        in   1     redirect from EXU/IDU; kill all buffered and incoming entries
//  id_ready_i     in   1     IDU accepts the head entry this cycle
//  id_valid_o     out  1     head entry valid
//  id_pc_o        out  PC_W  head pc
//  id_inst_o      out  32    head instruction, NOP_INST when empty
//  id_fault_o     out  1     head fetch returned rresp!=2'b00
//  ovf_err_o      out  1     sticky: push attempted while full
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - count=0, rd/wr pointers=0, ovf_err_o=0.
//   - Outputs: id_valid_o=0, id_pc_o=0, id_inst_o=NOP_INST, id_fault_o=0, pc_stall_o=0.
//   - Reset mid-stream discards all entries; no entry survives reset.
//  Handshakes
//   - push = ifu_valid_i & ~full & ~flush_i.
//   - pop  = id_valid_o & id_ready_i & ~flush_i.
//   - full = (count==DEPTH). pc_stall_o = full, decoded from registered count only.
//     No combinational path from id_ready_i or ifu_valid_i to pc_stall_o.
//   - Push and pop in the same cycle: both occur, count unchanged. Allowed at any count < DEPTH.
//   - When full, pop frees the slot next cycle. A push in that same cycle is rejected.
//   - ifu_valid_i while full and ~flush_i: entry dropped, ovf_err_o<=1.
//     ovf_err_o clears only on reset.
//  Latency
//   - Entry pushed in cycle N is visible on id_*_o in cycle N+1 at the earliest. No bypass.
//   - Outputs are driven from the head storage entry; id_valid_o = (count!=0).
//  Storage
//   - Per entry: {pc[PC_W-1:0], inst[31:0], fault}, with fault = |ifu_rresp_i.
//   - Pointers are log2(DEPTH) bits and wrap naturally mod DEPTH.
//   - count is log2(DEPTH)+1 bits and never exceeds DEPTH.
//  Flush
//   - flush_i=1: next cycle count=0, pointers=0, id_valid_o=0.
//   - flush_i overrides push and pop in the same cycle. Incoming ifu_valid_i is discarded.
//     The head is not consumed, even if id_ready_i=1.
//   - flush_i while empty: no effect besides pointer reset.
//  Empty
//   - id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0, id_fault_o=0.
//   - id_ready_i is ignored.
//  Fault entries
//   - Flow like normal entries; inst is kept raw.
//   - The consumer raises the instruction-access exception from id_fault_o.
// STRUCTURE
//  Shared package ysyx_22050019_pkg:
//   - NOP_INST constant.
//   - AXI resp constants (OKAY=2'b00).
//   - typedef ifid_entry_t {pc, inst, fault}.
//  One natural sub-module: ysyx_22050019_sync_fifo
//   - Parameterised width/depth, with push/pop/flush, count, full, empty.
//   - This block wraps it and adds output muxing (NOP/zero when empty), fault encoding and the overflow flag.
// TESTING
//  1. Single push pc=0x8000_0000, inst=0x0000_0413, rresp=0, id_ready_i=0
//     -> cycle+1: id_valid_o=1, id_pc_o=0x80000000, id_inst_o=0x00000413, id_fault_o=0.
//  2. Push 0x80000000 and 0x80000004 with id_ready_i=0
//     -> pc_stall_o=1 after 2nd push.
//     Then 3rd ifu_valid_i -> ovf_err_o=1, head still 0x80000000.
//     Then id_ready_i=1 -> pc_stall_o=0 next cycle.
//  3. Streaming push+pop every cycle, pcs 0x80000000..0x8000003C, id_ready_i=1
//     -> outputs in order, 1-cycle latency, count<=1, pc_stall_o never 1, pointers wrap.
//  4. Full buffer; flush_i=1 with ifu_valid_i=1 and id_ready_i=1 in the same cycle
//     -> next cycle id_valid_o=0, id_inst_o=0x00000013, pc_stall_o=0, incoming entry absent.
//  5. Push with rresp=2'b10 -> head id_fault_o=1, inst passed raw.
//     Next entry with rresp=0 -> id_fault_o=0.
//  6. Assert rst_n=0 asynchronously mid-cycle with 2 entries
//     -> outputs at reset values immediately, without waiting for a clock edge.
//     ovf_err_o=0; after release, first push behaves as in test 1.

Source files
------------

// File: rtl/ysyx_22050019_ifid_buf_pkg.sv
// Shared IF/ID definitions: NOP encoding, AXI response codes and the
// buffered fetch entry layout.
package ysyx_22050019_pkg;

  localparam int          XLEN     = 64;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            fault;
  } ifid_entry_t;

  // Any non-OKAY beat marks the instruction as an access fault.
  function automatic logic resp_fault(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22050019_ifid_buf_if.sv
// Fetch-side and decode-side signals of the IF/ID buffer, bundled so the
// buffer (slave) and its environment (master) share one declaration.
interface ysyx_22050019_ifid_buf_if #(
  parameter int PC_W = 64
);
  logic            ifu_valid_i;
  logic [PC_W-1:0] ifu_pc_i;
  logic [31:0]     ifu_inst_i;
  logic [1:0]      ifu_rresp_i;
  logic            pc_stall_o;
  logic            flush_i;
  logic            id_ready_i;
  logic            id_valid_o;
  logic [PC_W-1:0] id_pc_o;
  logic [31:0]     id_inst_o;
  logic            id_fault_o;
  logic            ovf_err_o;

  modport master (
    output ifu_valid_i, ifu_pc_i, ifu_inst_i, ifu_rresp_i, flush_i, id_ready_i,
    input  pc_stall_o, id_valid_o, id_pc_o, id_inst_o, id_fault_o, ovf_err_o
  );

  modport slave (
    input  ifu_valid_i, ifu_pc_i, ifu_inst_i, ifu_rresp_i, flush_i, id_ready_i,
    output pc_stall_o, id_valid_o, id_pc_o, id_inst_o, id_fault_o, ovf_err_o
  );
endinterface

// File: rtl/ysyx_22050019_sync_fifo.sv
// Synchronous FIFO with flush; pointers wrap mod DEPTH (power of two).
// Storage is not reset: only the pointers and occupancy decide what is valid.
module ysyx_22050019_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ysyx_22050019_ifid_buf.sv
// IF->ID decoupling buffer: queues committed fetches, presents the head to
// decode (NOP when empty), back-pressures fetch and flushes on redirect.
module ysyx_22050019_ifid_buf #(
  parameter int          DEPTH    = 2,
  parameter int          PC_W     = 64,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22050019_ifid_buf_if.slave bus
);
  import ysyx_22050019_pkg::ifid_entry_t;
  import ysyx_22050019_pkg::resp_fault;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(ifid_entry_t);

  ifid_entry_t   wr_entry;
  ifid_entry_t   rd_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf_err;

  assign push = bus.ifu_valid_i & ~full & ~bus.flush_i;
  assign pop  = ~empty & bus.id_ready_i & ~bus.flush_i;

  always_comb begin
    wr_entry               = '0;
    wr_entry.pc[PC_W-1:0]  = bus.ifu_pc_i;
    wr_entry.inst          = bus.ifu_inst_i;
    wr_entry.fault         = resp_fault(bus.ifu_rresp_i);
  end

  ysyx_22050019_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush_i),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky until reset: a fetch arrived with nowhere to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (bus.ifu_valid_i & full & ~bus.flush_i) begin
      ovf_err <= 1'b1;
    end
  end

  assign bus.pc_stall_o = full;
  assign bus.ovf_err_o  = ovf_err;
  assign bus.id_valid_o = (count != '0);
  assign bus.id_pc_o    = empty ? '0       : rd_entry.pc[PC_W-1:0];
  assign bus.id_inst_o  = empty ? NOP_INST : rd_entry.inst;
  assign bus.id_fault_o = empty ? 1'b0     : rd_entry.fault;

endmodule

// File: tb/tb_ysyx_22050019_ifid_buf.sv
// Directed bench for the IF/ID buffer: vector table plus hand-written
// streaming and asynchronous-reset sequences.
module tb_ysyx_22050019_ifid_buf;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [1:0]  rresp;
    logic        flush;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_fault;
    logic        e_stall;
    logic        e_ovf;
  } vec_t;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int NV = 18;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [NV];

  ysyx_22050019_ifid_buf_if #(.PC_W(64)) bus ();

  ysyx_22050019_ifid_buf #(
    .DEPTH    (2),
    .PC_W     (64),
    .NOP_INST (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                              input logic [1:0] rr, input logic fl, input logic rd,
                              input logic ev, input logic [63:0] epc, input logic [31:0] einst,
                              input logic ef, input logic es, input logic eo);
    vec_t t;
    t.valid = v;  t.pc = pc;  t.inst = inst;  t.rresp = rr;  t.flush = fl;  t.ready = rd;
    t.e_valid = ev;  t.e_pc = epc;  t.e_inst = einst;  t.e_fault = ef;
    t.e_stall = es;  t.e_ovf = eo;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [63:0] epc,
                           input logic [31:0] einst, input logic ef, input logic es,
                           input logic eo);
    chk({tag, ".valid"}, 64'(bus.id_valid_o), 64'(ev));
    chk({tag, ".pc"},    bus.id_pc_o,         epc);
    chk({tag, ".inst"},  64'(bus.id_inst_o),  64'(einst));
    chk({tag, ".fault"}, 64'(bus.id_fault_o), 64'(ef));
    chk({tag, ".stall"}, 64'(bus.pc_stall_o), 64'(es));
    chk({tag, ".ovf"},   64'(bus.ovf_err_o),  64'(eo));
  endtask

  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                      input logic [1:0] rr, input logic fl, input logic rd);
    bus.ifu_valid_i = v;
    bus.ifu_pc_i    = pc;
    bus.ifu_inst_i  = inst;
    bus.ifu_rresp_i = rr;
    bus.flush_i     = fl;
    bus.id_ready_i  = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.ifu_valid_i = 1'b0;
    bus.ifu_pc_i    = '0;
    bus.ifu_inst_i  = '0;
    bus.ifu_rresp_i = '0;
    bus.flush_i     = 1'b0;
    bus.id_ready_i  = 1'b0;
    rst_n = 1'b0;

    //            v  pc             inst          rr    fl rd | ev epc            einst         ef es eo
    vecs[0]  = mk(0, 64'h0,         32'h0,        2'b00,0, 0,   0, 64'h0,         NOP,          0, 0, 0);
    vecs[1]  = mk(1, 64'h80000000,  32'h00000413, 2'b00,0, 0,   1, 64'h80000000,  32'h00000413, 0, 0, 0);
    vecs[2]  = mk(1, 64'h80000004,  32'h00000493, 2'b00,0, 0,   1, 64'h80000000,  32'h00000413, 0, 1, 0);
    vecs[3]  = mk(1, 64'h80000008,  32'h00000513, 2'b00,0, 0,   1, 64'h80000000,  32'h00000413, 0, 1, 1);
    vecs[4]  = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   1, 64'h80000004,  32'h00000493, 0, 0, 1);
    vecs[5]  = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   0, 64'h0,         NOP,          0, 0, 1);
    vecs[6]  = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   0, 64'h0,         NOP,          0, 0, 1);
    vecs[7]  = mk(1, 64'h80000010,  32'h00100093, 2'b00,0, 0,   1, 64'h80000010,  32'h00100093, 0, 0, 1);
    vecs[8]  = mk(1, 64'h80000014,  32'h00200113, 2'b00,0, 0,   1, 64'h80000010,  32'h00100093, 0, 1, 1);
    vecs[9]  = mk(1, 64'h80000018,  32'h00300193, 2'b00,1, 1,   0, 64'h0,         NOP,          0, 0, 1);
    vecs[10] = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   0, 64'h0,         NOP,          0, 0, 1);
    vecs[11] = mk(1, 64'h80000020,  32'hFFFFFFFF, 2'b10,0, 0,   1, 64'h80000020,  32'hFFFFFFFF, 1, 0, 1);
    vecs[12] = mk(1, 64'h80000024,  32'h00000513, 2'b00,0, 1,   1, 64'h80000024,  32'h00000513, 0, 0, 1);
    vecs[13] = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   0, 64'h0,         NOP,          0, 0, 1);
    vecs[14] = mk(1, 64'h80000030,  32'h00000613, 2'b01,0, 0,   1, 64'h80000030,  32'h00000613, 1, 0, 1);
    vecs[15] = mk(1, 64'h80000034,  32'h00000693, 2'b00,0, 0,   1, 64'h80000030,  32'h00000613, 1, 1, 1);
    vecs[16] = mk(1, 64'h80000038,  32'h00000713, 2'b00,0, 1,   1, 64'h80000034,  32'h00000693, 0, 0, 1);
    vecs[17] = mk(0, 64'h0,         32'h0,        2'b00,0, 1,   0, 64'h0,         NOP,          0, 0, 1);

    #1;
    check_out("reset", 0, 64'h0, NOP, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].valid, vecs[i].pc, vecs[i].inst, vecs[i].rresp, vecs[i].flush, vecs[i].ready);
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst,
                vecs[i].e_fault, vecs[i].e_stall, vecs[i].e_ovf);
    end

    // Streaming: one push and one pop per cycle, head tracks the newest fetch.
    for (int i = 0; i < 16; i++) begin
      step(1, 64'h80000000 + 64'(4 * i), 32'h10000000 | 32'(i), 2'b00, 0, 1);
      check_out($sformatf("stream%0d", i), 1, 64'h80000000 + 64'(4 * i),
                32'h10000000 | 32'(i), 0, 0, 1);
    end
    step(0, 64'h0, 32'h0, 2'b00, 0, 1);
    check_out("stream_drain", 0, 64'h0, NOP, 0, 0, 1);

    // Asynchronous reset in mid-cycle with two entries held.
    step(1, 64'h80000040, 32'h00000793, 2'b00, 0, 0);
    step(1, 64'h80000044, 32'h00000813, 2'b10, 0, 0);
    check_out("prerst", 1, 64'h80000040, 32'h00000793, 0, 1, 1);
    bus.ifu_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 64'h0, NOP, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("rst_hold", 0, 64'h0, NOP, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 64'h0, 32'h0, 2'b00, 0, 0);
    check_out("post_rst_idle", 0, 64'h0, NOP, 0, 0, 0);
    step(1, 64'h80000000, 32'h00000413, 2'b00, 0, 0);
    check_out("post_rst_push", 1, 64'h80000000, 32'h00000413, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
